// File: rtl/frame_deserializer.sv
// -----------------------------------------------------------------------------
// frame_deserializer
//
// Receives the byte stream produced by the channel serializer. Each frame is
// HEADER, NUM_CHANNELS data bytes and FOOTER. The data bytes are collected in a
// shadow buffer. When a good footer arrives, the buffer is published on
// frame_data. A wrong footer byte aborts the frame. Beats are counted only
// when din_valid is high, so the stream may contain idle gaps.
//
// Optional build macro: DESER_ERR_CNT_EN adds a saturating count of aborted
// frames on err_count.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   din          incoming byte
//   din_valid    din carries a beat this cycle
//   frame_data   last good frame; channel k is in bits [8k+7:8k]
//   frame_valid  one-cycle pulse: frame_data has just been updated
//   frame_err    one-cycle pulse: frame aborted because of a bad footer
//   busy         high while a frame is in progress (COLLECT or FOOTER)
//   err_count    (DESER_ERR_CNT_EN only) saturating count of frame_err pulses
// -----------------------------------------------------------------------------
module frame_deserializer #(
    parameter logic [7:0] HEADER       = 8'hAA,
    parameter logic [7:0] FOOTER       = 8'hFF,
    parameter int         NUM_CHANNELS = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  din,
    input  logic                        din_valid,
    output logic [8*NUM_CHANNELS-1:0]   frame_data,
    output logic                        frame_valid,
    output logic                        frame_err,
`ifdef DESER_ERR_CNT_EN
    output logic [15:0]                 err_count,
`endif
    output logic                        busy
);

    localparam int CNT_W = $clog2(NUM_CHANNELS);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FOOTER  = 2'd2
    } state_t;

    state_t                       state;
    state_t                       state_next;
    logic [CNT_W-1:0]             cnt;
    logic [8*NUM_CHANNELS-1:0]    shadow;

    logic                         last_slot;
    logic                         start_frame;
    logic                         wr_slot;
    logic                         commit;
    logic                         abort;

    assign last_slot = (cnt == CNT_W'(NUM_CHANNELS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HUNT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_HUNT: begin
                if (din_valid && din == HEADER) begin
                    state_next = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (din_valid && last_slot) begin
                    state_next = ST_FOOTER;
                end
            end
            ST_FOOTER: begin
                // Good or bad footer, the byte is consumed and hunting restarts.
                // A bad footer equal to HEADER is therefore not taken as a start.
                if (din_valid) begin
                    state_next = ST_HUNT;
                end
            end
            default: state_next = ST_HUNT;
        endcase
    end

    // Output / datapath control decode
    always_comb begin
        start_frame = 1'b0;
        wr_slot     = 1'b0;
        commit      = 1'b0;
        abort       = 1'b0;
        case (state)
            ST_HUNT:    start_frame = din_valid && (din == HEADER);
            ST_COLLECT: wr_slot     = din_valid;
            ST_FOOTER: begin
                commit = din_valid && (din == FOOTER);
                abort  = din_valid && (din != FOOTER);
            end
            default: ;
        endcase
    end

    // Registered datapath and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            shadow      <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_valid <= commit;
            frame_err   <= abort;
            // Loaded from the next state so busy lines up with the state register.
            busy        <= (state_next != ST_HUNT);
            if (start_frame) begin
                cnt <= '0;
            end else if (wr_slot) begin
                shadow[8*cnt +: 8] <= din;
                cnt                <= cnt + 1'b1;
            end
            if (commit) begin
                frame_data <= shadow;
            end
        end
    end

`ifdef DESER_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (abort && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_deserializer.sv
module tb_frame_deserializer;

    localparam int          NC  = 16;
    localparam logic [7:0]  HDR = 8'hAA;
    localparam logic [7:0]  FTR = 8'hFF;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [7:0]          din = 8'h00;
    logic                din_valid = 1'b0;
    logic [8*NC-1:0]     frame_data;
    logic                frame_valid;
    logic                frame_err;
    logic                busy;
`ifdef DESER_ERR_CNT_EN
    logic [15:0]         err_count;
`endif

    frame_deserializer #(.HEADER(HDR), .FOOTER(FTR), .NUM_CHANNELS(NC)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
`ifdef DESER_ERR_CNT_EN
        .err_count   (err_count),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int fv_cycles[$];

    // Reference model: phase -1 = waiting for a header, 0..NC-1 = next data
    // slot to fill, NC = expecting the footer.
    int              m_phase = -1;
    logic [7:0]      m_buf [NC];
    logic [8*NC-1:0] exp_data = '0;
    logic            exp_fv   = 1'b0;
    logic            exp_fe   = 1'b0;
    logic            exp_busy = 1'b0;
    logic [15:0]     exp_ecnt = '0;

    task automatic model(input logic r, input logic v, input logic [7:0] d);
        exp_fv = 1'b0;
        exp_fe = 1'b0;
        if (r) begin
            m_phase  = -1;
            exp_data = '0;
            exp_ecnt = '0;
            for (int k = 0; k < NC; k++) m_buf[k] = 8'h00;
        end else if (v) begin
            if (m_phase < 0) begin
                if (d == HDR) m_phase = 0;
            end else if (m_phase < NC) begin
                m_buf[m_phase] = d;
                m_phase++;
            end else begin
                if (d == FTR) begin
                    for (int k = 0; k < NC; k++) exp_data[8*k +: 8] = m_buf[k];
                    exp_fv = 1'b1;
                end else begin
                    exp_fe = 1'b1;
                    if (exp_ecnt != 16'hFFFF) exp_ecnt = exp_ecnt + 16'd1;
                end
                m_phase = -1;
            end
        end
        exp_busy = (m_phase >= 0);
    endtask

    task automatic chk(input string tag, input logic [8*NC-1:0] obs, input logic [8*NC-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: drive, advance model, then sample 1 time unit after the edge.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        rst       = r;
        din_valid = v;
        din       = d;
        model(r, v, d);
        @(posedge clk);
        #1;
        cyc++;
        if (frame_valid === 1'b1) fv_cycles.push_back(cyc);
        chk("frame_valid", {{(8*NC-1){1'b0}}, frame_valid}, {{(8*NC-1){1'b0}}, exp_fv});
        chk("frame_err",   {{(8*NC-1){1'b0}}, frame_err},   {{(8*NC-1){1'b0}}, exp_fe});
        chk("busy",        {{(8*NC-1){1'b0}}, busy},        {{(8*NC-1){1'b0}}, exp_busy});
        chk("frame_data",  frame_data, exp_data);
        chk("excl",        {{(8*NC-1){1'b0}}, (frame_valid & frame_err)}, '0);
`ifdef DESER_ERR_CNT_EN
        chk("err_count",   {{(8*NC-16){1'b0}}, err_count}, {{(8*NC-16){1'b0}}, exp_ecnt});
`endif
    endtask

    task automatic beat(input logic [7:0] d, input int gap);
        step(1'b0, 1'b1, d);
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic frame_seq(input logic [7:0] base, input int gap, input logic [7:0] ftr);
        beat(HDR, gap);
        for (int k = 0; k < NC; k++) beat(base + 8'(k), gap);
        beat(ftr, gap);
    endtask

    logic [8*NC-1:0] ref_seq;
    logic [7:0]      rb;

    initial begin
        for (int k = 0; k < NC; k++) m_buf[k] = 8'h00;
        #1;
        // Reset state
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, HDR);
        step(1'b0, 1'b0, 8'h00);

        // Good frame, contiguous
        frame_seq(8'h00, 0, FTR);
        ref_seq = 128'h0F0E0D0C0B0A09080706050403020100;
        chk("contig_data", frame_data, ref_seq);
        step(1'b0, 1'b0, 8'h00);

        // Gapped input, same content; busy checked every cycle via the model
        frame_seq(8'h00, 1, FTR);
        chk("gapped_data", frame_data, ref_seq);

        // Bad footer keeps the previous frame, then a good frame follows
        beat(HDR, 0);
        for (int k = 0; k < NC; k++) beat(8'h55, 0);
        beat(8'h11, 0);
        chk("badftr_keep", frame_data, ref_seq);
        frame_seq(8'h40, 0, FTR);

        // Bad footer equal to HEADER must not start a frame
        beat(HDR, 0);
        for (int k = 0; k < NC; k++) beat(8'h66, 0);
        beat(HDR, 0);
        for (int k = 0; k < 4; k++) beat(8'h77, 0);
        beat(FTR, 0);

        // Hunt and embedded markers
        beat(8'h12, 0);
        beat(8'h34, 0);
        beat(HDR, 0);
        for (int k = 0; k < NC; k++) beat((k % 2 == 0) ? HDR : FTR, 0);
        beat(FTR, 0);
        chk("marker_slot0", {{(8*NC-8){1'b0}}, frame_data[7:0]},  {{(8*NC-8){1'b0}}, 8'hAA});
        chk("marker_slot1", {{(8*NC-8){1'b0}}, frame_data[15:8]}, {{(8*NC-8){1'b0}}, 8'hFF});

        // Back-to-back frames
        fv_cycles.delete();
        frame_seq(8'h10, 0, FTR);
        frame_seq(8'h20, 0, FTR);
        total++;
        assert (fv_cycles.size() == 2 && (fv_cycles[1] - fv_cycles[0]) == NC + 2) else begin
            bad++;
            $error("FAIL b2b_period observed_pulses=%0d expected_period=%0d", fv_cycles.size(), NC + 2);
        end

        // Reset mid-frame after 5 data bytes, then a fresh frame
        beat(HDR, 0);
        for (int k = 0; k < 5; k++) beat(8'h90 + 8'(k), 0);
        step(1'b1, 1'b1, 8'h95);
        chk("rst_data", frame_data, '0);
        frame_seq(8'hC0, 0, FTR);

`ifdef DESER_ERR_CNT_EN
        // Saturation: preload near the top and abort two frames
        force dut.err_count = 16'hFFFE;
        #1;
        release dut.err_count;
        exp_ecnt = 16'hFFFE;
        for (int n = 0; n < 2; n++) begin
            beat(HDR, 0);
            for (int k = 0; k < NC; k++) beat(8'h01, 0);
            beat(8'h02, 0);
        end
        chk("err_sat", {{(8*NC-16){1'b0}}, err_count}, {{(8*NC-16){1'b0}}, 16'hFFFF});
`endif

        // Randomized traffic: good/bad frames, junk, gaps, occasional reset
        for (int it = 0; it < 80; it++) begin
            int kind;
            int gmax;
            kind = $urandom_range(0, 9);
            gmax = $urandom_range(0, 2);
            if (kind <= 5) begin
                beat(HDR, $urandom_range(0, gmax));
                for (int k = 0; k < NC; k++) beat(8'($urandom), $urandom_range(0, gmax));
                beat(FTR, $urandom_range(0, gmax));
            end else if (kind <= 7) begin
                beat(HDR, $urandom_range(0, gmax));
                for (int k = 0; k < NC; k++) beat(8'($urandom), $urandom_range(0, gmax));
                rb = 8'($urandom);
                if (rb == FTR) rb = 8'h00;
                beat(rb, $urandom_range(0, gmax));
            end else if (kind == 8) begin
                for (int k = 0; k < 4; k++) beat(8'($urandom), $urandom_range(0, gmax));
            end else begin
                beat(HDR, 0);
                for (int k = 0; k < $urandom_range(0, NC); k++) beat(8'($urandom), 0);
                step(1'b1, 1'($urandom), 8'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_deserializer.md
Name: frame_deserializer

Overview:
- Downstream stage of the channel serializer. Consumes its byte stream, which is framed as HEADER, then NUM_CHANNELS data bytes, then FOOTER.
- Rebuilds one parallel word of NUM_CHANNELS bytes per frame and flags framing errors.
- Sits between the link receive side and the per-channel processing logic.
- Beats are counted only on din_valid, so gaps between bytes are tolerated.

Parameters:
- HEADER, 8'hAA, start-of-frame byte.
- FOOTER, 8'hFF, end-of-frame byte.
- NUM_CHANNELS, 16, data bytes per frame; legal range 2..256.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  8  incoming byte.
- din_valid  input  1  din is valid this cycle.
- frame_data  output  8*NUM_CHANNELS  last good frame; channel k in bits [8k+7:8k].
- frame_valid  output  1  one-cycle pulse: frame_data has just been updated.
- frame_err  output  1  one-cycle pulse: frame aborted due to bad footer.
- busy  output  1  high while in COLLECT or FOOTER.

Behaviour:
- Reset: synchronous, active-high, applied on the clk edge with rst=1.
  - State goes to HUNT, channel counter to 0, shadow buffer to 0.
  - frame_data=0, frame_valid=0, frame_err=0, busy=0.
  - Reset mid-frame discards the partial frame; frame_data keeps no old content (it is 0).
- Registered outputs; frame_valid and frame_err default to 0 every cycle unless set below.
- A cycle with din_valid=0 changes nothing. State, counter and buffer hold.
- States (2-bit encoding):
  - HUNT: on din_valid with din==HEADER go to COLLECT with counter=0. Any other byte is discarded and the state stays HUNT.
  - COLLECT: on din_valid, write din into shadow slot [counter] and increment the counter. When the written slot is NUM_CHANNELS-1, go to FOOTER. Data bytes equal to HEADER or FOOTER are ordinary data and carry no special meaning.
  - FOOTER: on din_valid with din==FOOTER, copy the shadow buffer (including the byte written on the last COLLECT beat) to frame_data and go to HUNT. frame_valid=1 on the next cycle.
  - FOOTER, bad byte: on din_valid with din!=FOOTER, frame_data is unchanged and the state goes to HUNT. frame_err=1 on the next cycle. The bad byte is consumed and is not evaluated as a HEADER, even if it equals HEADER.
- busy is registered and equals (state != HUNT).
- Latency: frame_valid and the new frame_data appear one cycle after the footer beat.
- Back-to-back frames are supported: a HEADER on the cycle directly after the footer beat is accepted. The minimum frame period is NUM_CHANNELS+2 valid beats.
- Counter width is clog2(NUM_CHANNELS). There is no wrap-around inside a frame, because it resets on the HEADER beat.
- frame_valid and frame_err are never high together.

Optional Feature:
- Macro DESER_ERR_CNT_EN.
- Defined:
  - Adds output err_count [15:0].
  - Increments on every frame_err pulse and saturates at 16'hFFFF with no wrap.
  - Cleared by rst.
- Undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan:
- Good frame, contiguous: after reset, drive AA, 00..0F, FF with din_valid=1 every cycle -> single frame_valid pulse 1 cycle after FF. frame_data = 128'h0F0E0D0C0B0A09080706050403020100. frame_err stays 0.
- Gapped input: same frame with din_valid toggling 1/0 each cycle -> identical frame_data and one frame_valid. busy is high from the cycle after AA until the cycle after FF.
- Bad footer: AA, 16 bytes of 55, then 11 -> frame_err pulse and no frame_valid. frame_data keeps the previous frame. With DESER_ERR_CNT_EN, err_count goes 0->1. A following good frame is received correctly.
- Hunt and embedded markers: send 12, 34, then AA, data bytes AA,FF,AA,FF,... (16 bytes), then FF -> leading 12, 34 ignored. frame_data slot0=AA, slot1=FF, and so on. One frame_valid.
- Back-to-back and reset: two frames with no idle cycle between them -> two frame_valid pulses 18 cycles apart. Then assert rst after 5 data bytes of a third frame -> all outputs 0 next cycle. A fresh frame after reset is decoded correctly.
- Saturation (macro on): force 65536 bad-footer frames (or preload via bench hierarchy at FFFE) -> err_count stops at FFFF.
